// File: rtl/regfile_writeback_buffer_if.sv
// Bus bundle for the register file write-back buffer: producer handshake,
// register file write port, forwarding lookups and occupancy.
interface regfile_writeback_buffer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 1,
   parameter int DEPTH  = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_dest;
   logic [DATA_W-1:0] in_data;
   logic              wb_hold;
   logic              rf_regWrite;
   logic [ADDR_W-1:0] rf_writeReg;
   logic [DATA_W-1:0] rf_writeData;
   logic [ADDR_W-1:0] fwd_addr1;
   logic [ADDR_W-1:0] fwd_addr2;
   logic              fwd_hit1;
   logic              fwd_hit2;
   logic [DATA_W-1:0] fwd_data1;
   logic [DATA_W-1:0] fwd_data2;
   logic [CNT_W-1:0]  count;

   // Side that drives results in and reads the write port / forwarding
   modport master (
      output in_valid, in_dest, in_data, wb_hold, fwd_addr1, fwd_addr2,
      input  in_ready, rf_regWrite, rf_writeReg, rf_writeData,
             fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
   );

   // The buffer itself
   modport slave (
      input  in_valid, in_dest, in_data, wb_hold, fwd_addr1, fwd_addr2,
      output in_ready, rf_regWrite, rf_writeReg, rf_writeData,
             fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
   );
endinterface

// File: rtl/regfile_writeback_buffer.sv
// In-order write-back FIFO in front of the register file write port.
// Results are queued on a valid/ready handshake, drained one per cycle
// unless wb_hold is set, and the youngest pending value for each of two
// decode read addresses is forwarded combinationally.
module regfile_writeback_buffer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 1,
   parameter int DEPTH  = 2
) (
   input logic                     clk,
   input logic                     rst,
   regfile_writeback_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] dest_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              ready;
   logic              push;
   logic              pop;
   logic              hit1;
   logic              hit2;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;

   // Handshake and drain decisions; a full buffer refuses even if it pops
   always_comb begin
      ready = !rst && (count < FULL_COUNT);
      push  = bus.in_valid && ready;
      pop   = !rst && (count != '0) && !bus.wb_hold;
   end

   assign bus.in_ready     = ready;
   assign bus.rf_regWrite  = pop;
   assign bus.rf_writeReg  = dest_mem[rd_ptr];
   assign bus.rf_writeData = data_mem[rd_ptr];
   assign bus.count        = count;
   assign bus.fwd_hit1     = hit1;
   assign bus.fwd_hit2     = hit2;
   assign bus.fwd_data1    = data1;
   assign bus.fwd_data2    = data2;

   // Entry storage is written on accept only; it is never cleared because
   // count alone decides which entries are meaningful
   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[wr_ptr] <= bus.in_dest;
         data_mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointers and occupancy; push and pop together leave count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Forwarding walks entries oldest to youngest so the youngest match
   // overwrites older ones; the head being written this cycle still counts
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit1  = 1'b0;
      hit2  = 1'b0;
      data1 = '0;
      data2 = '0;
      idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (CNT_W'(i) < count) begin
            if (dest_mem[idx] == bus.fwd_addr1) begin
               hit1  = 1'b1;
               data1 = data_mem[idx];
            end
            if (dest_mem[idx] == bus.fwd_addr2) begin
               hit2  = 1'b1;
               data2 = data_mem[idx];
            end
         end
      end
      if (rst) begin
         hit1  = 1'b0;
         hit2  = 1'b0;
         data1 = '0;
         data2 = '0;
      end
   end
endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Self-checking bench for regfile_writeback_buffer: directed scenarios then
// random traffic, each cycle compared against a queue-based reference model.
module tb_regfile_writeback_buffer;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 1;
   localparam int DEPTH  = 2;

   typedef struct {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic   clk;
   logic   rst;
   int     checks;
   int     failures;
   entry_t model_q[$];

   regfile_writeback_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   regfile_writeback_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, check outputs against the model, then
   // advance the model across the clock edge
   task automatic applyStimulus(input bit r, input bit v, input logic [ADDR_W-1:0] dest,
                                input logic [DATA_W-1:0] data, input bit hold,
                                input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
      bit                exp_ready;
      bit                exp_write;
      bit                exp_hit1;
      bit                exp_hit2;
      logic [DATA_W-1:0] exp_data1;
      logic [DATA_W-1:0] exp_data2;
      entry_t            e;
      rst           = r;
      bus.in_valid  = v;
      bus.in_dest   = dest;
      bus.in_data   = data;
      bus.wb_hold   = hold;
      bus.fwd_addr1 = a1;
      bus.fwd_addr2 = a2;
      #1;
      exp_ready = !r && (model_q.size() < DEPTH);
      exp_write = !r && (model_q.size() > 0) && !hold;
      exp_hit1  = 1'b0;
      exp_hit2  = 1'b0;
      exp_data1 = '0;
      exp_data2 = '0;
      if (!r) begin
         for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (!exp_hit1 && model_q[i].dest == a1) begin
               exp_hit1  = 1'b1;
               exp_data1 = model_q[i].data;
            end
            if (!exp_hit2 && model_q[i].dest == a2) begin
               exp_hit2  = 1'b1;
               exp_data2 = model_q[i].data;
            end
         end
      end
      checkOutput("count", 32'(bus.count), 32'(model_q.size()));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      checkOutput("rf_regWrite", 32'(bus.rf_regWrite), 32'(exp_write));
      if (exp_write) begin
         checkOutput("rf_writeReg", 32'(bus.rf_writeReg), 32'(model_q[0].dest));
         checkOutput("rf_writeData", 32'(bus.rf_writeData), 32'(model_q[0].data));
      end
      checkOutput("fwd_hit1", 32'(bus.fwd_hit1), 32'(exp_hit1));
      checkOutput("fwd_data1", 32'(bus.fwd_data1), 32'(exp_data1));
      checkOutput("fwd_hit2", 32'(bus.fwd_hit2), 32'(exp_hit2));
      checkOutput("fwd_data2", 32'(bus.fwd_data2), 32'(exp_data2));
      @(posedge clk);
      if (r) begin
         model_q.delete();
      end else begin
         if (exp_write) begin
            void'(model_q.pop_front());
         end
         if (v && exp_ready) begin
            e.dest = dest;
            e.data = data;
            model_q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   // Directed scenarios followed by random traffic
   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_dest   = '0;
      bus.in_data   = '0;
      bus.wb_hold   = 1'b0;
      bus.fwd_addr1 = '0;
      bus.fwd_addr2 = '0;
      @(posedge clk);
      @(negedge clk);

      $display("[TB] reset with pending entries");
      applyStimulus(0, 1, 1'b0, 8'h12, 1, 1'b1, 1'b0);
      applyStimulus(0, 1, 1'b1, 8'h34, 1, 1'b1, 1'b0);
      applyStimulus(1, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);

      $display("[TB] single write");
      applyStimulus(0, 1, 1'b1, 8'hA5, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);

      $display("[TB] full and backpressure");
      applyStimulus(0, 1, 1'b0, 8'h11, 1, 1'b0, 1'b1);
      applyStimulus(0, 1, 1'b1, 8'h22, 1, 1'b0, 1'b1);
      applyStimulus(0, 1, 1'b0, 8'h33, 1, 1'b0, 1'b1);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);

      $display("[TB] forwarding priority");
      applyStimulus(0, 1, 1'b1, 8'h33, 1, 1'b1, 1'b0);
      applyStimulus(0, 1, 1'b1, 8'h44, 1, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 1, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 1, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);

      $display("[TB] simultaneous push and pop");
      applyStimulus(0, 1, 1'b0, 8'h55, 1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 1'(i + 1), 8'h66 + 8'(i), 0, 1'b1, 1'b0);
      end
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);

      $display("[TB] reset mid-drain");
      applyStimulus(0, 1, 1'b0, 8'h5A, 1, 1'b0, 1'b1);
      applyStimulus(0, 1, 1'b1, 8'hC3, 1, 1'b0, 1'b1);
      applyStimulus(1, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      applyStimulus(0, 1, 1'b1, 8'h77, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 9) < 6),
                       1'($urandom),
                       8'($urandom),
                       ($urandom_range(0, 9) < 3),
                       1'($urandom),
                       1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_writeback_buffer.md
# regfile_writeback_buffer

Write-side companion to the processor's two-entry 8-bit register file: accepts results (destination register plus data) from the execute/memory stages over a valid/ready handshake, buffers them in a small in-order FIFO and drains them one per cycle onto the register file write port (regWrite / writeReg / writeData). It also forwards the newest still-pending value for up to two read addresses so decode sees correct operands before a buffered result reaches the register file.

## Interface
Parameters:
- DATA_W, 8, data width; matches the register file word.
- ADDR_W, 1, register address width (2 registers).
- DEPTH, 2, FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  buffer can accept this cycle.
- in_dest  input  ADDR_W  destination register.
- in_data  input  DATA_W  result value.
- wb_hold  input  1  when 1, no write is issued to the register file this cycle.
- rf_regWrite  output  1  register file write enable.
- rf_writeReg  output  ADDR_W  register file write address.
- rf_writeData  output  DATA_W  register file write data.
- fwd_addr1, fwd_addr2  input  ADDR_W  read addresses being decoded.
- fwd_hit1, fwd_hit2  output  1  a pending entry matches the address.
- fwd_data1, fwd_data2  output  DATA_W  newest matching pending data; 0 when no hit.
- count  output  clog2(DEPTH+1)  number of pending entries.

## Operation
- Storage: DEPTH entries of {dest, data}; write pointer, read pointer, and count; pointers wrap modulo DEPTH.
- Push: accepted when in_valid && in_ready; entry written at wr_ptr, wr_ptr advances.
- in_ready = !rst && (count < DEPTH). No pass-through when full, even if a pop occurs in the same cycle.
- Pop: pop = rf_regWrite. rf_regWrite = !rst && (count != 0) && !wb_hold; rf_writeReg / rf_writeData = head entry (combinational from storage, rd_ptr); rd_ptr advances on the edge.
- Push and pop in the same cycle: count unchanged; both pointers advance; FIFO order preserved.
- Ordering: writes reach the register file strictly in acceptance order, including repeated writes to the same register.
- Forwarding (combinational): search all valid entries, including the head being written this cycle; the youngest matching entry wins. The in_data currently being presented is not forwarded. fwd_hit = 0 and fwd_data = 0 when no entry matches.
- Reset: count, wr_ptr, rd_ptr ← 0; pending entries are discarded and never written. While rst = 1: rf_regWrite = 0, in_ready = 0, fwd_hit* = 0. Entry storage contents are not reset.
- count never exceeds DEPTH and never underflows; a pop is impossible when empty and a push is impossible when full, by construction.

## Timing
- Latency: an entry accepted at edge N is visible on the rf_* port in cycle N+1, if wb_hold = 0. It reaches the register file at edge N+1.
- Forwarding for an accepted entry is valid from cycle N+1 until the edge that pops it.
- Throughput: 1 push and 1 pop per cycle in steady state.
- After reset deasserts: in_ready = 1, rf_regWrite = 0, count = 0 in the first cycle.
- wb_hold affects only the pop; pushes continue until the buffer is full.

## Test plan
- Reset: preload 2 entries, assert rst for 1 cycle -> count = 0, rf_regWrite = 0 during and after, in_ready = 1 next cycle, no stale write ever appears.
- Single write: push (dest = 1, 0xA5) at cycle 0 with wb_hold = 0 -> cycle 1: rf_regWrite = 1, rf_writeReg = 1, rf_writeData = 0xA5; cycle 2: count = 0, rf_regWrite = 0.
- Full/backpressure: wb_hold = 1, push (0, 0x11) then (1, 0x22) -> count = 2, in_ready = 0, third push (0, 0x33) not accepted; release hold -> writes 0x11 then 0x22 on consecutive cycles, then in_ready = 1.
- Forwarding priority: wb_hold = 1, push (1, 0x33) then (1, 0x44); fwd_addr1 = 1, fwd_addr2 = 0 -> fwd_hit1 = 1, fwd_data1 = 0x44, fwd_hit2 = 0, fwd_data2 = 0. Release one pop -> fwd_data1 remains 0x44.
- Simultaneous push/pop: count = 1 holding (0, 0x55), push (1, 0x66) with wb_hold = 0 -> count stays 1, 0x55 is written that cycle, 0x66 is written next cycle, pointers wrap correctly over 4 back-to-back iterations.
- Reset mid-drain: count = 2, wb_hold = 0, rst = 1 for one cycle -> no rf write in the rst cycle, count = 0 after, and a subsequent push (1, 0x77) drains correctly.
